// File: rtl/sigdelay_pkg.sv
// Shared types and default sizing for the delay-line sequencer.
package sigdelay_pkg;
    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_RD_LATENCY    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        SLEW = 2'd3
    } dly_state_t;
endpackage

// File: rtl/sigdelay_ctrl_slew.sv
// Offset/target register pair: direct load, target-only load, and a +/-1 step toward target.
module dly_slew #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_direct,
    input  logic          load_target,
    input  logic          step,
    input  logic [AW-1:0] value,
    output logic [AW-1:0] offset,
    output logic          done
);
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] target;

    // A step taken together with a target load still heads for the old target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
            target <= '0;
        end else if (load_direct) begin
            offset <= value;
            target <= value;
        end else begin
            if (load_target) target <= value;
            if (step && (offset != target))
                offset <= (offset < target) ? offset + ONE : offset - ONE;
        end
    end

    assign done = (offset == target);
endmodule

// File: rtl/sigdelay_ctrl.sv
// Delay-line sequencer: turns sample strobes into wr/rd pulses, pre-fills the buffer and slews the offset.
module sigdelay_ctrl
    import sigdelay_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int RD_LATENCY    = DEF_RD_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic                     delay_load,
    input  logic [ADDRESS_WIDTH-1:0] delay_req,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [ADDRESS_WIDTH-1:0] delay_offset,
    output logic                     out_valid,
    output logic                     filling,
    output logic                     slewing,
    output dly_state_t               dbg_state
);
    localparam logic [ADDRESS_WIDTH:0] FILL_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    dly_state_t               state, state_next;
    logic [ADDRESS_WIDTH:0]   fill_cnt;
    logic [RD_LATENCY-1:0]    pipe;
    logic [ADDRESS_WIDTH-1:0] fill_target;
    logic                     wr_next, rd_next, fill_inc, fill_clr, flush;
    logic                     load_direct, load_target, step, slew_done;

    dly_slew #(.AW(ADDRESS_WIDTH)) u_slew (
        .clk         (clk),
        .rst         (rst),
        .load_direct (load_direct),
        .load_target (load_target),
        .step        (step),
        .value       (delay_req),
        .offset      (delay_offset),
        .done        (slew_done)
    );

    always_comb begin
        state_next  = state;
        wr_next     = 1'b0;
        rd_next     = 1'b0;
        fill_inc    = 1'b0;
        fill_clr    = 1'b0;
        load_direct = 1'b0;
        load_target = 1'b0;
        step        = 1'b0;
        fill_target = delay_offset;
        // Dropping enable overrides every other event in the same cycle.
        flush       = (state != IDLE) && !enable;
        case (state)
            IDLE: begin
                fill_clr    = 1'b1;
                load_direct = delay_load;
                if (enable) state_next = FILL;
            end
            FILL: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    load_direct = delay_load;
                    if (delay_load) fill_target = delay_req;
                    wr_next  = sample_valid;
                    fill_inc = sample_valid;
                    if (fill_cnt >= {1'b0, fill_target}) state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    wr_next     = sample_valid;
                    rd_next     = sample_valid;
                    load_target = delay_load;
                    if (delay_load && (delay_req != delay_offset)) state_next = SLEW;
                end
            end
            SLEW: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    wr_next     = sample_valid;
                    rd_next     = sample_valid;
                    load_target = delay_load;
                    step        = sample_valid;
                    if (!delay_load && slew_done) state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            filling  <= 1'b0;
            slewing  <= 1'b0;
            fill_cnt <= '0;
            pipe     <= '0;
        end else begin
            state   <= state_next;
            wr_en   <= wr_next;
            rd_en   <= rd_next;
            filling <= (state_next == FILL);
            slewing <= (state_next == SLEW);
            if (fill_clr)
                fill_cnt <= '0;
            else if (fill_inc && (fill_cnt != '1))
                fill_cnt <= fill_cnt + FILL_ONE;
            // One bit per rd_en pulse tracks the datapath read latency.
            if (flush) begin
                pipe <= '0;
            end else begin
                pipe[0] <= rd_en;
                for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[RD_LATENCY-1];
    assign dbg_state = state;
endmodule

// File: tb/tb_sigdelay_ctrl.sv
// Bench for sigdelay_ctrl: directed scenarios with fixed expectations plus a randomized run against a reference model.
module tb_sigdelay_ctrl;
    import sigdelay_pkg::*;

    localparam int AW = 8;
    localparam int RL = 2;
    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_RUN  = 2;
    localparam int M_SLEW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0, sample_valid = 1'b0, delay_load = 1'b0;
    logic [AW-1:0] delay_req = '0;
    logic          wr_en, rd_en, out_valid, filling, slewing;
    logic [AW-1:0] delay_offset;
    dly_state_t    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (spec-level view).
    int          m_state, m_off, m_tgt, m_fill, m_cycle;
    bit          m_wr, m_rd;
    logic [31:0] exp_q[$];

    sigdelay_ctrl #(.ADDRESS_WIDTH(AW), .RD_LATENCY(RL)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .delay_load   (delay_load),
        .delay_req    (delay_req),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .delay_offset (delay_offset),
        .out_valid    (out_valid),
        .filling      (filling),
        .slewing      (slewing),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = M_IDLE; m_off = 0; m_tgt = 0; m_fill = 0;
        m_wr = 1'b0; m_rd = 1'b0;
        exp_q.delete();
    endtask

    // Applies one clock edge of spec behaviour to the model; out_valid is a list of due cycles.
    task automatic model_update();
        int old_off, old_tgt, limit;
        m_cycle++;
        old_off = m_off;
        old_tgt = m_tgt;
        m_wr = 1'b0;
        m_rd = 1'b0;
        if (m_state != M_IDLE && !enable) begin
            m_state = M_IDLE;
            exp_q.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (delay_load) begin m_off = int'(delay_req); m_tgt = int'(delay_req); end
                    if (enable) begin m_state = M_FILL; m_fill = 0; end
                end
                M_FILL: begin
                    limit = delay_load ? int'(delay_req) : m_off;
                    if (delay_load) begin m_off = int'(delay_req); m_tgt = int'(delay_req); end
                    m_wr = sample_valid;
                    if (m_fill >= limit) m_state = M_RUN;
                    if (sample_valid) m_fill++;
                end
                M_RUN: begin
                    m_wr = sample_valid;
                    m_rd = sample_valid;
                    if (sample_valid) exp_q.push_back(32'(m_cycle + RL));
                    if (delay_load) begin
                        m_tgt = int'(delay_req);
                        if (m_tgt != m_off) m_state = M_SLEW;
                    end
                end
                default: begin
                    m_wr = sample_valid;
                    m_rd = sample_valid;
                    if (sample_valid) exp_q.push_back(32'(m_cycle + RL));
                    if (sample_valid && old_off != old_tgt)
                        m_off = (old_tgt > old_off) ? old_off + 1 : old_off - 1;
                    if (delay_load) m_tgt = int'(delay_req);
                    else if (old_off == old_tgt) m_state = M_RUN;
                end
            endcase
        end
        while (exp_q.size() > 0 && int'(exp_q[0]) < m_cycle) void'(exp_q.pop_front());
    endtask

    // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
    task automatic step(input bit en, input bit sv, input bit dl, input logic [AW-1:0] dr);
        enable = en; sample_valid = sv; delay_load = dl; delay_req = dr;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        enable = 1'b0; sample_valid = 1'b0; delay_load = 1'b0; delay_req = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1; sample_valid = 1'b1; delay_load = 1'b1; delay_req = 8'd7;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wr_en, rd_en, out_valid, filling, slewing, delay_offset} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected all zero",
                     {wr_en, rd_en, out_valid, filling, slewing, delay_offset});
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE);
        end
        do_reset();
    endtask

    task automatic test_fill_then_run();
        step(1, 0, 1, 8'd4);
        n_checks++;
        if (filling !== 1'b1 || delay_offset !== 8'd4) begin
            n_fail++;
            $display("FAIL fill_entry filling=%b offset=%0d expected 1/4", filling, delay_offset);
        end
        for (int s = 1; s <= 4; s++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if ({wr_en, rd_en, filling} !== 3'b101) begin
                n_fail++;
                $display("FAIL fill_sample%0d wr/rd/filling=%b expected 101", s, {wr_en, rd_en, filling});
            end
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
        end
        n_checks++;
        if (filling !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_exit filling=%b expected 0", filling);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if ({wr_en, rd_en, out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL run_sample5 wr/rd/ov=%b expected 110", {wr_en, rd_en, out_valid});
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (out_valid !== (i == RL)) begin
                n_fail++;
                $display("FAIL ov_latency cycle+%0d got %b expected %b", i, out_valid, (i == RL));
            end
        end
    endtask

    task automatic test_zero_delay();
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'd0);
        n_checks++;
        if (delay_offset !== 8'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL zero_load offset=%0d state=%0d expected 0/IDLE", delay_offset, dbg_state);
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (filling !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_fill filling=%b expected 1", filling);
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (filling !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_fill_len filling=%b expected 0 after one cycle", filling);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if ({wr_en, rd_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL zero_first_sample wr/rd=%b expected 11", {wr_en, rd_en});
        end
    endtask

    task automatic test_slew_up();
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'd10);
        step(1, 0, 0, 0);
        for (int s = 0; s < 10; s++) step(1, 1, 0, 0);
        n_checks++;
        if (filling !== 1'b1) begin
            n_fail++;
            $display("FAIL refill10 filling=%b expected 1 after 10 samples", filling);
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (filling !== 1'b0 || delay_offset !== 8'd10) begin
            n_fail++;
            $display("FAIL run10 filling=%b offset=%0d expected 0/10", filling, delay_offset);
        end
        step(1, 0, 1, 8'd13);
        n_checks++;
        if (slewing !== 1'b1 || delay_offset !== 8'd10) begin
            n_fail++;
            $display("FAIL slew_start slewing=%b offset=%0d expected 1/10", slewing, delay_offset);
        end
        for (int s = 1; s <= 3; s++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (delay_offset !== 8'(10 + s) || slewing !== 1'b1 || wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL slew_up%0d offset=%0d slewing=%b wr=%b expected %0d/1/1",
                         s, delay_offset, slewing, wr_en, 10 + s);
            end
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (slewing !== 1'b0 || dbg_state !== RUN || delay_offset !== 8'd13) begin
            n_fail++;
            $display("FAIL slew_up_done slewing=%b offset=%0d expected 0/13", slewing, delay_offset);
        end
    endtask

    task automatic test_retarget();
        logic [AW-1:0] exp_seq [3];
        exp_seq[0] = 8'd14; exp_seq[1] = 8'd13; exp_seq[2] = 8'd12;
        step(1, 0, 1, 8'd20);
        step(1, 1, 0, 0);
        step(1, 0, 1, 8'd12);
        n_checks++;
        if (delay_offset !== exp_seq[0] || slewing !== 1'b1) begin
            n_fail++;
            $display("FAIL retarget_hold offset=%0d slewing=%b expected 14/1", delay_offset, slewing);
        end
        for (int s = 1; s <= 2; s++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (delay_offset !== exp_seq[s]) begin
                n_fail++;
                $display("FAIL retarget_step%0d offset=%0d expected %0d", s, delay_offset, exp_seq[s]);
            end
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (slewing !== 1'b0 || delay_offset !== 8'd12) begin
            n_fail++;
            $display("FAIL retarget_done slewing=%b offset=%0d expected 0/12", slewing, delay_offset);
        end
    endtask

    task automatic test_back_to_back_load();
        step(1, 1, 1, 8'd15);
        n_checks++;
        if ({wr_en, rd_en, slewing} !== 3'b111 || delay_offset !== 8'd12) begin
            n_fail++;
            $display("FAIL sim_load wr/rd/slew=%b offset=%0d expected 111/12",
                     {wr_en, rd_en, slewing}, delay_offset);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if (delay_offset !== 8'd13) begin
            n_fail++;
            $display("FAIL sim_next offset=%0d expected 13", delay_offset);
        end
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        n_checks++;
        if (slewing !== 1'b0 || delay_offset !== 8'd15) begin
            n_fail++;
            $display("FAIL sim_done slewing=%b offset=%0d expected 0/15", slewing, delay_offset);
        end
    endtask

    task automatic test_enable_drop();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 8'd5);
        n_checks++;
        if ({wr_en, rd_en, out_valid, filling, slewing} !== 5'd0 || dbg_state !== IDLE
            || delay_offset !== 8'd15) begin
            n_fail++;
            $display("FAIL drop outs=%b state=%0d offset=%0d expected 00000/IDLE/15",
                     {wr_en, rd_en, out_valid, filling, slewing}, dbg_state, delay_offset);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_flush out_valid=%b expected 0", out_valid);
        end
        step(1, 0, 0, 0);
        for (int s = 1; s <= 15; s++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if ({wr_en, rd_en, filling} !== 3'b101) begin
                n_fail++;
                $display("FAIL refill_s%0d wr/rd/filling=%b expected 101", s, {wr_en, rd_en, filling});
            end
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (filling !== 1'b0 || dbg_state !== RUN) begin
            n_fail++;
            $display("FAIL refill_exit filling=%b state=%0d expected 0/RUN", filling, dbg_state);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 1, 8'd3);
        step(1, 1, 0, 0);
        enable = 1'b1; sample_valid = 1'b1; delay_load = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({wr_en, rd_en, out_valid, filling, slewing, delay_offset} !== 13'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL async_rst outs=%b state=%0d expected all zero/IDLE",
                     {wr_en, rd_en, out_valid, filling, slewing, delay_offset}, dbg_state);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_random();
        int off_cnt = 0;
        logic [AW-1:0] dr;
        logic [AW+4:0] act, exp_v;
        bit en, exp_ov;
        for (int c = 0; c < 3000; c++) begin
            if (off_cnt == 0 && $urandom_range(0, 79) == 0) off_cnt = $urandom_range(1, 3);
            en = (off_cnt == 0);
            if (off_cnt > 0) off_cnt--;
            case ($urandom_range(0, 9))
                0:       dr = 8'd0;
                1:       dr = 8'd255;
                default: dr = 8'($urandom_range(0, 15));
            endcase
            step(en, 1'($urandom_range(0, 1)), ($urandom_range(0, 14) == 0), dr);
            exp_ov = (exp_q.size() > 0 && int'(exp_q[0]) == m_cycle);
            act   = {wr_en, rd_en, out_valid, filling, slewing, delay_offset};
            exp_v = {m_wr, m_rd, exp_ov, (m_state == M_FILL), (m_state == M_SLEW), 8'(m_off)};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL random c=%0d wr,rd,ov,fill,slew,offset got %b expected %b", c, act, exp_v);
            end
        end
    endtask

    initial begin
        m_cycle = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_fill_then_run();
        test_zero_delay();
        test_slew_up();
        test_retarget();
        test_back_to_back_load();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
